// File: rtl/hilo_div_ctrl.sv
// Iterative restoring divider / sequencer for DIV and DIVU in the EX stage.
// Operands are latched on start. The pipeline is stalled while the divider iterates,
// then HI (remainder) and LO (quotient) are presented with a one-cycle write strobe.
// Optional feature macro: DIV_EARLY_EXIT_EN. When it is defined, an operation whose
// |dividend| < |divisor| finishes directly from IDLE with lo=0 and hi=dividend.
module hilo_div_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic              annul_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  output logic              stall_o,
  output logic              ready_o,
  output logic              hilo_we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CntW  = $clog2(DATA_W) + 1;
  localparam int unsigned PartW = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StByZero = 2'd1,
    StOn     = 2'd2,
    StEnd    = 2'd3
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [PartW-1:0]  part_q;     // {remainder (DATA_W+1), dividend/quotient (DATA_W)}
  logic [DATA_W-1:0] divisor_q;
  logic              neg_quot_q;
  logic              neg_rem_q;
  logic              ready_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic              accept;
  logic              dividend_neg;
  logic              divisor_neg;
  logic              divisor_zero;
  logic [DATA_W-1:0] dividend_abs;
  logic [DATA_W-1:0] divisor_abs;
  logic [PartW-1:0]  part_shift;
  logic [DATA_W+1:0] trial;
  logic [PartW-1:0]  part_next;
  logic [DATA_W-1:0] quot_mag;
  logic [DATA_W-1:0] rem_mag;
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;
  logic              last_step;

  // Operand decode: acceptance and signed magnitudes of the incoming operands.
  always_comb begin
    accept       = start_i & ~annul_i;
    dividend_neg = signed_i & opdata1_i[DATA_W-1];
    divisor_neg  = signed_i & opdata2_i[DATA_W-1];
    divisor_zero = (opdata2_i == '0);
    // The negation of the most negative value wraps to itself, which is the correct
    // unsigned magnitude.
    dividend_abs = dividend_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    divisor_abs  = divisor_neg  ? (~opdata2_i + 1'b1) : opdata2_i;
  end

  // One restoring step: shift left, trial subtract, and keep the result when it is non-negative.
  always_comb begin
    part_shift = {part_q[PartW-2:0], 1'b0};
    trial      = {1'b0, part_shift[PartW-1:DATA_W]} - {2'b00, divisor_q};
    if (trial[DATA_W+1]) begin
      part_next = part_shift;
    end else begin
      part_next = {trial[DATA_W:0], part_shift[DATA_W-1:1], 1'b1};
    end
    quot_mag  = part_next[DATA_W-1:0];
    rem_mag   = part_next[2*DATA_W-1:DATA_W];
    quot_fix  = neg_quot_q ? (~quot_mag + 1'b1) : quot_mag;
    rem_fix   = neg_rem_q  ? (~rem_mag + 1'b1)  : rem_mag;
    last_step = (cnt_q == CntW'(DATA_W - 1));
  end

  // Stall covers the accepting IDLE cycle and every busy cycle; END releases the pipe.
  always_comb begin
    stall_o   = ((state_q == StIdle) & accept) | (state_q == StOn) | (state_q == StByZero);
    ready_o   = ready_q;
    hilo_we_o = ready_q;
    hi_o      = hi_q;
    lo_o      = lo_q;
  end

  // Sequencer FSM with the datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      part_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      ready_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (divisor_zero) begin
              state_q <= StByZero;
`ifdef DIV_EARLY_EXIT_EN
            end else if (dividend_abs < divisor_abs) begin
              // The quotient is zero and the remainder is the dividend itself.
              state_q <= StEnd;
              ready_q <= 1'b1;
              hi_q    <= opdata1_i;
              lo_q    <= '0;
`endif
            end else begin
              state_q    <= StOn;
              part_q     <= {{(DATA_W + 1){1'b0}}, dividend_abs};
              divisor_q  <= divisor_abs;
              neg_quot_q <= dividend_neg ^ divisor_neg;
              neg_rem_q  <= dividend_neg;
              cnt_q      <= '0;
            end
          end
        end
        StByZero: begin
          if (annul_i) begin
            state_q <= StIdle;
          end else begin
            state_q <= StEnd;
            ready_q <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
          end
        end
        StOn: begin
          if (annul_i) begin
            state_q <= StIdle;
          end else begin
            part_q <= part_next;
            cnt_q  <= cnt_q + CntW'(1);
            if (last_step) begin
              state_q <= StEnd;
              ready_q <= 1'b1;
              hi_q    <= rem_fix;
              lo_q    <= quot_fix;
            end
          end
        end
        StEnd: begin
          // The result is committed in this cycle, so start and annul are ignored here.
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed, table-driven bench for hilo_div_ctrl, with hand sequences for annul,
// start during END, and reset applied in the middle of an operation.
module tb_hilo_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        stall_o;
  logic        ready_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  hilo_div_ctrl #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .annul_i   (annul_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .stall_o   (stall_o),
    .ready_o   (ready_o),
    .hilo_we_o (hilo_we_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

`ifdef DIV_EARLY_EXIT_EN
  localparam int EarlyCyc = 1;
`else
  localparam int EarlyCyc = 33;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  localparam int NumVec = 14;
  vec_t vecs[NumVec];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request; the start is sampled at the next rising edge (cycle 0).
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
  endtask

  // Observe from cycle 0 until ready_o is seen or the cycle budget runs out.
  task automatic wait_ready(output int cyc, output logic [31:0] hi, output logic [31:0] lo,
                            output int stall_bad, output int we_bad);
    cyc       = -1;
    hi        = '0;
    lo        = '0;
    stall_bad = 0;
    we_bad    = 0;
    @(negedge clk);
    if (!stall_o) stall_bad++;
    if (ready_o) cyc = 0;
    for (int c = 1; c <= 40 && cyc < 0; c++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      @(negedge clk);
      if (hilo_we_o !== ready_o) we_bad++;
      if (ready_o) begin
        cyc = c;
        hi  = hi_o;
        lo  = lo_o;
        if (stall_o) stall_bad++;
      end else if (!stall_o) begin
        stall_bad++;
      end
    end
    start_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          sbad;
    int          wbad;
    int          seen;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [5:0]  mask;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'h0000_0002, 32'h0000_000E, 33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,        32'h0000_0000, 32'h0000_0000, 2};
    vecs[5]  = '{1'b0, 32'd5,          32'd9,        32'h0000_0005, 32'h0000_0000, EarlyCyc};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'h0000_0000, 32'hFFFF_FFFF, 33};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 33};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFF2, 33};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFD,  32'd5,        32'hFFFF_FFFD, 32'h0000_0000, EarlyCyc};
    vecs[10] = '{1'b0, 32'h1234_5678,  32'h0000_0100, 32'h0000_0078, 32'h0012_3456, 33};
    vecs[11] = '{1'b1, 32'd5,          32'd0,        32'h0000_0000, 32'h0000_0000, 2};
    vecs[12] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, EarlyCyc};
    vecs[13] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 33};

    rst       = 1'b0;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    annul_i   = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;

    // Reset state.
    #12;
    check("rst_ready", {31'b0, ready_o}, 32'd0);
    check("rst_we", {31'b0, hilo_we_o}, 32'd0);
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NumVec; i++) begin
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_ready(cyc, hi, lo, sbad, wbad);
      check($sformatf("v%0d_ready_cycle", i), 32'(cyc), 32'(vecs[i].cyc));
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_stall_pattern", i), 32'(sbad), 32'd0);
      check($sformatf("v%0d_we_eq_ready", i), 32'(wbad), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_ready_pulse", i), {31'b0, ready_o}, 32'd0);
      check($sformatf("v%0d_hi_hold", i), hi_o, vecs[i].hi);
      check($sformatf("v%0d_lo_hold", i), lo_o, vecs[i].lo);
    end

    // Annul in IDLE blocks acceptance.
    @(posedge clk);
    #1;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd5;
    opdata2_i = 32'd0;
    #1;
    check("annul_idle_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    seen    = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ready_o || hilo_we_o) seen++;
    end
    check("annul_idle_no_ready", 32'(seen), 32'd0);

    // Annul in BYZERO drops the operation.
    launch(1'b0, 32'd5, 32'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_byzero_stall", {31'b0, stall_o}, 32'd1);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    @(negedge clk);
    check("annul_byzero_ready", {31'b0, ready_o}, 32'd0);
    check("annul_byzero_stall_after", {31'b0, stall_o}, 32'd0);

    // Annul in END is ignored.
    launch(1'b0, 32'd5, 32'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_end_ready", {31'b0, ready_o}, 32'd1);
    check("annul_end_we", {31'b0, hilo_we_o}, 32'd1);
    @(posedge clk);
    #1;
    annul_i = 1'b0;

    // Start held through END is ignored there and accepted in the following IDLE cycle.
    launch(1'b0, 32'd9, 32'd0);
    mask = '0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      mask[c] = ready_o;
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("start_in_end_ready_mask", {26'b0, mask}, 32'b100100);
    @(negedge clk);
    @(negedge clk);

    // Annul at cycle 10 of an ON operation, with a new request accepted in cycle 11.
    launch(1'b0, 32'd100, 32'd7);
    @(negedge clk);
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      if (c == 10) annul_i = 1'b1;
      @(negedge clk);
      if (ready_o || hilo_we_o) seen++;
    end
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    #1;
    check("annul_on_stall_c11", {31'b0, stall_o}, 32'd0);
    check("annul_on_ready_c11", {31'b0, ready_o}, 32'd0);
    check("annul_on_no_ready_c1_10", 32'(seen), 32'd0);
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    wait_ready(cyc, hi, lo, sbad, wbad);
    check("restart_ready_cycle_abs", 32'(cyc + 11), 32'd44);
    check("restart_hi", hi, 32'd2);
    check("restart_lo", lo, 32'd14);

    // Reset asserted at cycle 15 of an operation.
    launch(1'b0, 32'd100, 32'd7);
    @(negedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      if (c == 15) rst = 1'b0;
    end
    #1;
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_lo", lo_o, 32'd0);
    check("midrst_ready", {31'b0, ready_o}, 32'd0);
    check("midrst_we", {31'b0, hilo_we_o}, 32'd0);
    check("midrst_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (hilo_we_o) seen++;
    end
    check("midrst_no_write", 32'(seen), 32'd0);
    launch(1'b0, 32'd100, 32'd7);
    wait_ready(cyc, hi, lo, sbad, wbad);
    check("postrst_ready_cycle", 32'(cyc), 32'd33);
    check("postrst_hi", hi, 32'd2);
    check("postrst_lo", lo, 32'd14);
    check("postrst_stall_pattern", 32'(sbad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
